// File: rtl/sub_result_fifo_if.sv
// ============================================================================
// Module      : sub_result_fifo_if
// Description : Handshake and statistics bundle between a subtractor result
//               producer, the sub_result_fifo and its sink.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sub_result_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_diff;
  logic             in_borrow;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_mag;
  logic             out_neg;
  logic             out_zero;
  logic [CW-1:0]    count;
  logic             clr_stats;
  logic [7:0]       neg_count;
  logic [7:0]       zero_count;

  modport slave (
    input  in_valid, in_diff, in_borrow, out_ready, clr_stats,
    output in_ready, out_valid, out_mag, out_neg, out_zero, count,
           neg_count, zero_count
  );

  modport master (
    output in_valid, in_diff, in_borrow, out_ready, clr_stats,
    input  in_ready, out_valid, out_mag, out_neg, out_zero, count,
           neg_count, zero_count
  );
endinterface

`default_nettype wire

// File: rtl/sub_result_fifo.sv
// ============================================================================
// Module      : sub_result_fifo
// Description : Converts subtractor difference/borrow pairs to sign-magnitude
//               and buffers them in a show-ahead FIFO. Statistics counters
//               are built only when SUB_RESULT_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  sub_result_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [WIDTH+1:0] mem_q [DEPTH];

  logic             push_w, pop_w;
  logic             in_ready_w, out_valid_w;
  logic [WIDTH-1:0] mag_w;
  logic             neg_w, zero_w;
  logic [WIDTH+1:0] head_w;

  // Handshake flags derive only from the registered state, never from inputs
  assign in_ready_w  = (state_q != ST_FULL);
  assign out_valid_w = (state_q != ST_EMPTY);
  assign push_w      = bus.in_valid && in_ready_w;
  assign pop_w       = out_valid_w && bus.out_ready;

  // Borrow with diff==0 yields mag=0, neg=1: the -256 case is kept as-is
  assign mag_w  = bus.in_borrow ? (~bus.in_diff + WIDTH'(1)) : bus.in_diff;
  assign neg_w  = bus.in_borrow;
  assign zero_w = !bus.in_borrow && (bus.in_diff == '0);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_EMPTY: begin
        if (push_w) begin
          count_d = CW'(1);
          state_d = ST_PARTIAL;
        end
      end
      ST_PARTIAL: begin
        if (push_w && !pop_w) begin
          count_d = count_q + CW'(1);
          state_d = (count_d == CW'(DEPTH)) ? ST_FULL : ST_PARTIAL;
        end else if (pop_w && !push_w) begin
          count_d = count_q - CW'(1);
          state_d = (count_d == '0) ? ST_EMPTY : ST_PARTIAL;
        end
      end
      ST_FULL: begin
        if (pop_w) begin
          count_d = count_q - CW'(1);
          state_d = ST_PARTIAL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push_w) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_w)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push_w) mem_q[wr_ptr_q] <= {neg_w, zero_w, mag_w};
  end

  // Outputs are masked while empty so stale memory never reaches the sink
  assign head_w        = mem_q[rd_ptr_q];
  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_mag   = out_valid_w ? head_w[WIDTH-1:0] : '0;
  assign bus.out_zero  = out_valid_w && head_w[WIDTH];
  assign bus.out_neg   = out_valid_w && head_w[WIDTH+1];
  assign bus.count     = count_q;

`ifdef SUB_RESULT_STATS_EN
  logic [7:0] neg_cnt_q, zero_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr_stats) begin
      neg_cnt_q  <= '0;
      zero_cnt_q <= '0;
    end else if (push_w) begin
      if (neg_w && (neg_cnt_q != 8'hFF))   neg_cnt_q  <= neg_cnt_q + 8'd1;
      if (zero_w && (zero_cnt_q != 8'hFF)) zero_cnt_q <= zero_cnt_q + 8'd1;
    end
  end

  assign bus.neg_count  = neg_cnt_q;
  assign bus.zero_count = zero_cnt_q;
`else
  assign bus.neg_count  = 8'd0;
  assign bus.zero_count = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sub_result_fifo.sv
// ============================================================================
// Module      : tb_sub_result_fifo
// Description : Directed self-checking bench for sub_result_fifo (DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sub_result_fifo;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sub_result_fifo_if #(.WIDTH(8), .DEPTH(4)) bus ();

  sub_result_fifo #(.DEPTH(4), .WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_diff = 8'h00; bus.in_borrow = 1'b0;
    bus.out_ready = 1'b0; bus.clr_stats = 1'b0;
    step(); step();
    rst_n = 1'b1;
    checks++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags: count=%0d out_valid=%b in_ready=%b, need 0/0/1",
               bus.count, bus.out_valid, bus.in_ready);
    end
    checks++;
    if (bus.out_mag !== 8'd0 || bus.out_neg !== 1'b0 || bus.out_zero !== 1'b0 ||
        bus.neg_count !== 8'd0 || bus.zero_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_data: mag=%0d neg=%b zero=%b nc=%0d zc=%0d, need all 0",
               bus.out_mag, bus.out_neg, bus.out_zero, bus.neg_count, bus.zero_count);
    end
  endtask

  task automatic test_zero_push();
    bus.in_valid = 1'b1; bus.in_diff = 8'h00; bus.in_borrow = 1'b0; bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_mag !== 8'd0 || bus.out_zero !== 1'b1 ||
        bus.out_neg !== 1'b0 || bus.count !== 3'd1) begin
      errors++;
      $display("FAIL zero_head: valid=%b mag=%0d zero=%b neg=%b count=%0d, need 1/0/1/0/1",
               bus.out_valid, bus.out_mag, bus.out_zero, bus.out_neg, bus.count);
    end
    step();
    checks++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_pop: count=%0d valid=%b, need 0/0", bus.count, bus.out_valid);
    end
  endtask

  task automatic test_negative();
    logic [7:0] exp_nc;
`ifdef SUB_RESULT_STATS_EN
    exp_nc = 8'd1;
`else
    exp_nc = 8'd0;
`endif
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_diff = 8'h07; bus.in_borrow = 1'b1;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_mag !== 8'd249 || bus.out_neg !== 1'b1 || bus.out_zero !== 1'b0) begin
      errors++;
      $display("FAIL neg_conv: mag=%0d neg=%b zero=%b, need 249/1/0",
               bus.out_mag, bus.out_neg, bus.out_zero);
    end
    checks++;
    if (bus.neg_count !== exp_nc) begin
      errors++;
      $display("FAIL neg_count: got %0d need %0d", bus.neg_count, exp_nc);
    end
    step();
    checks++;
    if (bus.out_mag !== 8'd249 || bus.count !== 3'd1) begin
      errors++;
      $display("FAIL neg_hold: mag=%0d count=%0d, need 249/1", bus.out_mag, bus.count);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_order();
    bus.in_valid = 1'b1; bus.in_diff = 8'hFF; bus.in_borrow = 1'b0;
    step();
    bus.in_borrow = 1'b1;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_mag !== 8'd255 || bus.out_neg !== 1'b0 || bus.count !== 3'd2) begin
      errors++;
      $display("FAIL order_first: mag=%0d neg=%b count=%0d, need 255/0/2",
               bus.out_mag, bus.out_neg, bus.count);
    end
    bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.out_mag !== 8'd1 || bus.out_neg !== 1'b1 || bus.count !== 3'd1) begin
      errors++;
      $display("FAIL order_second: mag=%0d neg=%b count=%0d, need 1/1/1",
               bus.out_mag, bus.out_neg, bus.count);
    end
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_full();
    logic [7:0] exp_head [4];
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_borrow = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.in_diff = 8'(i);
      step();
    end
    checks++;
    if (bus.in_ready !== 1'b0 || bus.count !== 3'd4 || bus.out_mag !== 8'd1) begin
      errors++;
      $display("FAIL full_state: in_ready=%b count=%0d head=%0d, need 0/4/1",
               bus.in_ready, bus.count, bus.out_mag);
    end
    bus.in_diff = 8'd5;
    step();
    checks++;
    if (bus.count !== 3'd4 || bus.out_mag !== 8'd1) begin
      errors++;
      $display("FAIL full_reject: count=%0d head=%0d, need 4/1", bus.count, bus.out_mag);
    end
    // Full refuses the push at edge 1; later edges push and pop together
    exp_head = '{8'd2, 8'd3, 8'd4, 8'h11};
    bus.out_ready = 1'b1;
    bus.in_diff = 8'h10;
    for (int i = 0; i < 4; i++) begin
      step();
      bus.in_diff = 8'h11 + 8'(i);
      checks++;
      if (bus.out_mag !== exp_head[i] || bus.count !== 3'd3) begin
        errors++;
        $display("FAIL full_drain%0d: head=%0d count=%0d, need %0d/3",
                 i, bus.out_mag, bus.count, exp_head[i]);
      end
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (i < 2 && bus.out_mag !== 8'h12 + 8'(i)) begin
        errors++;
        $display("FAIL wrap_order%0d: head=%0d need %0d", i, bus.out_mag, 8'h12 + 8'(i));
      end else if (bus.count !== 3'(2 - i)) begin
        errors++;
        $display("FAIL wrap_count%0d: count=%0d need %0d", i, bus.count, 2 - i);
      end
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_stats();
    logic [7:0] exp_zc, exp_nc;
`ifdef SUB_RESULT_STATS_EN
    exp_zc = 8'd255;
    exp_nc = 8'd2;
`else
    exp_zc = 8'd0;
    exp_nc = 8'd0;
`endif
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_diff = 8'h00; bus.in_borrow = 1'b0;
    for (int i = 0; i < 300; i++) step();
    checks++;
    if (bus.zero_count !== exp_zc || bus.neg_count !== exp_nc || bus.count !== 3'd1) begin
      errors++;
      $display("FAIL stats_sat: zc=%0d nc=%0d count=%0d, need %0d/%0d/1",
               bus.zero_count, bus.neg_count, bus.count, exp_zc, exp_nc);
    end
    bus.clr_stats = 1'b1;
    step();
    bus.clr_stats = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.zero_count !== 8'd0 || bus.neg_count !== 8'd0) begin
      errors++;
      $display("FAIL stats_clr: zc=%0d nc=%0d, need 0/0", bus.zero_count, bus.neg_count);
    end
    step();
    checks++;
    if (bus.count !== 3'd0) begin
      errors++;
      $display("FAIL stats_drain: count=%0d need 0", bus.count);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_diff = 8'h07; bus.in_borrow = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (bus.count !== 3'd3) begin
      errors++;
      $display("FAIL mid_fill: count=%0d need 3", bus.count);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.out_mag !== 8'd0 || bus.out_neg !== 1'b0 || bus.out_zero !== 1'b0 ||
        bus.neg_count !== 8'd0 || bus.zero_count !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: count=%0d valid=%b ready=%b mag=%0d neg=%b zero=%b nc=%0d zc=%0d",
               bus.count, bus.out_valid, bus.in_ready, bus.out_mag, bus.out_neg,
               bus.out_zero, bus.neg_count, bus.zero_count);
    end
    step();
    checks++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_after: count=%0d valid=%b, need 0/0", bus.count, bus.out_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_zero_push();
    test_negative();
    test_order();
    test_full();
    test_stats();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/sub_result_fifo.md
# sub_result_fifo

Downstream consumer of the 8-bit subtractor: captures each difference/borrow pair, converts it to sign-magnitude with a zero flag, and buffers results in a small show-ahead FIFO with valid/ready handshakes. Optional statistics counters track negative and zero results. It sits between the combinational subtractor datapath and any slower sink, such as a display or serial formatter.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2
- WIDTH, 8, difference width; matches the subtractor
- clk  input  1  single clock; all logic on the rising edge
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  difference/borrow pair is presented
- in_ready  output  1  block can accept a pair (FIFO not full)
- in_diff  input  WIDTH  subtractor difference output
- in_borrow  input  1  subtractor borrow-out; 1 means a < b
- out_valid  output  1  head entry is available
- out_ready  input  1  sink accepts the head entry
- out_mag  output  WIDTH  magnitude of a-b
- out_neg  output  1  result was negative
- out_zero  output  1  result was exactly 0
- count  output  $clog2(DEPTH)+1  number of occupied entries
- clr_stats  input  1  synchronous clear of the statistics counters
- neg_count  output  8  saturating count of accepted negative results
- zero_count  output  8  saturating count of accepted zero results

## Operation
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Conversion at push:
  - in_borrow=0: mag=in_diff, neg=0, zero=(in_diff==0).
  - in_borrow=1: mag=(~in_diff+1) truncated to WIDTH, neg=1, zero=0.
  - Example: diff=0x07 with borrow=1 gives mag=249.
- Illegal pair borrow=1, diff=0 (meaning -256) is stored as mag=0, neg=1, zero=0. No other flagging.
- Storage: DEPTH x (WIDTH+2) memory with wr_ptr and rd_ptr of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH.
- Occupancy FSM, encoded from count:
  - EMPTY (count=0): push only -> PARTIAL. With DEPTH=2, a single push still reaches PARTIAL.
  - PARTIAL: push without pop -> count+1, becoming FULL at DEPTH. Pop without push -> count-1, becoming EMPTY at 0. Push and pop together -> count unchanged, both pointers advance.
  - FULL (count=DEPTH): in_ready=0, so a push is impossible. Pop -> PARTIAL.
- in_ready = (count != DEPTH). There is no same-cycle bypass, so a full FIFO refuses a push even when out_ready=1.
- Push in EMPTY with out_ready=1: the entry is not popped that cycle; out_valid rises on the next cycle.
- Statistics:
  - neg_count increments on each push with neg=1; zero_count increments on each push with zero=1.
  - Both saturate at 255.
  - clr_stats=1 zeroes both; it takes priority over an increment in the same cycle.

## Timing
- Reset (rst_n=0 at an edge):
  - count=0, pointers=0, out_valid=0, in_ready=1.
  - out_mag=0, out_neg=0, out_zero=0, neg_count=0, zero_count=0.
  - Memory contents are don't-care.
- Reset mid-operation discards all entries. An in-flight push is dropped.
- Latency is 1 cycle: a pair pushed at edge N is visible on out_* with out_valid=1 after edge N.
- out_mag, out_neg and out_zero come from the head entry (show-ahead). They are stable while out_valid=1 and out_ready=0.
- in_ready and out_valid are functions of registered count only; there are no combinational paths from in_valid or out_ready.
- The sink sees at most one pop per cycle, giving sustained throughput of 1 result per cycle when not full.

## Configuration
- SUB_RESULT_STATS_EN defined: neg_count and zero_count counters and clr_stats behave as specified in Operation.
- SUB_RESULT_STATS_EN undefined:
  - No counter registers are built.
  - neg_count and zero_count are driven constant 0, and clr_stats is ignored.
  - All ports remain present; FIFO behaviour is unchanged.

## Test plan
- Reset then single push of diff=0x00, borrow=0 with out_ready=1 -> next cycle out_valid=1, out_mag=0, out_zero=1, out_neg=0; popped the following edge, after which count=0.
- Push diff=0x07, borrow=1 (a=2, b=251) -> out_mag=249, out_neg=1; neg_count=1 when stats are enabled.
- Push diff=0xFF, borrow=0, then diff=0xFF, borrow=1 -> head entries read 255 with neg=0, then 1 with neg=1, in order.
- Hold out_ready=0 and push 5 pairs with DEPTH=4 -> in_ready=0 after the 4th push and the 5th is not accepted; count=4. Then hold out_ready=1 and in_valid=1 -> no push while full; 4 pops in order, then normal flow resumes. Verify pointer wrap.
- Push 300 zero results with stats enabled -> zero_count saturates at 255. clr_stats=1 on a push cycle -> 0. Without SUB_RESULT_STATS_EN -> both counters read 0 throughout.
- Assert rst_n=0 with count=3 -> after the edge count=0, out_valid=0, in_ready=1, all outputs 0.
